alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports, N=0,1: reqN_valid  in  1  requester N has an operation pending.
REQ-005 SHALL have ports, N=0,1: reqN_ready  out  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports, N=0,1: reqN_op  in  4  ALU operation code.
REQ-007 SHALL have ports, N=0,1: reqN_a / reqN_b  in  WIDTH  operands 1 and 2.
REQ-008 SHALL have port: rsp_valid  out  1  response available.
REQ-009 SHALL have port: rsp_ready  in  1  consumer takes response.
REQ-010 SHALL have port: rsp_id  out  1  index of requester that owns the response.
REQ-011 SHALL have port: rsp_result  out  WIDTH  captured ALU result.
REQ-012 SHALL have ports: rsp_negative, rsp_zero  out  1  captured ALU flags.
REQ-013 SHALL have port: rsp_err  out  1  op code 0 rejected.
REQ-014 SHALL have ports: alu_input1, alu_input2  out  WIDTH  operands driven to the shared ALU.
REQ-015 SHALL have port: alu_operation  out  4  op code driven to the shared ALU.
REQ-016 SHALL have ports: alu_out  in  WIDTH; alu_negative, alu_zero  in  1  combinational ALU outputs.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-018 IDLE: reqN_ready SHALL be 1 only for the granted requester, 0 in ISSUE and RESP.
REQ-019 Grant: only one valid requester -> it wins; both valid -> the requester not held in last_grant wins (round-robin).
REQ-020 On reqN_valid && reqN_ready: op, a, b and id N SHALL be latched; next state ISSUE if op != 0, else RESP.
REQ-021 op == 0: SHALL skip the ALU; response rsp_result=0, rsp_negative=0, rsp_zero=1, rsp_err=1.
REQ-022 ISSUE, exactly one cycle: alu_input1/alu_input2/alu_operation SHALL carry the latched a/b/op; alu_out, alu_negative, alu_zero SHALL be captured at the cycle's end; rsp_err=0; next RESP.
REQ-023 Outside ISSUE, alu_input1, alu_input2 and alu_operation SHALL be 0.
REQ-024 RESP: rsp_valid=1 with all rsp_* fields held stable until rsp_ready=1; on that cycle -> IDLE and last_grant <= rsp_id.
REQ-025 rsp_valid SHALL be 0 in IDLE and ISSUE.
REQ-026 Latency: acceptance in cycle T -> rsp_valid in cycle T+2 (ALU op) or T+1 (op 0); back-to-back throughput SHALL be one op per 3 cycles minimum.
REQ-027 A new request SHALL NOT be accepted while a response is outstanding, including the cycle rsp_ready is asserted.
REQ-028 Requester deasserting reqN_valid while not granted SHALL cause no state change; operands are sampled only at acceptance.
REQ-029 Response payload fields SHALL be WIDTH bits, unmodified from ALU; no sign or width conversion.

Reset
REQ-030 rst=1 at a rising edge SHALL force state IDLE and last_grant=1, so requester 0 wins the first tie.
REQ-031 rst=1 SHALL clear all rsp_* outputs and latched operands to 0.
REQ-032 rst during ISSUE or RESP SHALL abort the operation; no response is emitted for it.
REQ-033 req*_ready SHALL be 0 in any cycle rst=1.

Verification
REQ-034 Single op: req0 op=1 a=15 b=42, ALU model returns 57 -> req0_ready at T, alu_operation=1 at T+1, rsp_valid T+2, rsp_id=0, rsp_result=57.
REQ-035 Tie after reset: req0 and req1 valid simultaneously -> req0 served first, then req1; repeat tie -> req0; order alternates 0,1,0,1.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles with req1 valid -> rsp_* stable, req1_ready=0 throughout; accepted one cycle after rsp_ready=1.
REQ-037 Op 0: req1 op=0 -> rsp_valid at T+1, rsp_err=1, rsp_zero=1, rsp_result=0, alu_operation stays 0.
REQ-038 Flags: ALU model returns 0xFFFFFFFD, negative=1, zero=0 -> rsp_negative=1, rsp_zero=0, rsp_result=0xFFFFFFFD.
REQ-039 Reset mid-op: rst=1 during ISSUE -> next cycle IDLE, rsp_valid=0, alu_operation=0, no response for aborted op.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant picks one request in IDLE. The chosen operation is
// driven to the ALU for a single ISSUE cycle. The result is then held in RESP
// until the consumer takes it. Op code 0 bypasses the ALU and returns an error
// response straight away.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_negative,
    output logic             rsp_zero,
    output logic             rsp_err,

    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_negative,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // last_grant_reg holds the requester served most recently. It loses the next tie.
    logic last_grant_reg, last_grant_next;

    // The operation latched at acceptance. Operands are not sampled again later.
    logic [3:0]       op_reg,  op_next;
    logic [WIDTH-1:0] a_reg,   a_next;
    logic [WIDTH-1:0] b_reg,   b_next;
    logic             id_reg,  id_next;

    // Captured response payload. It stays unchanged until the next operation writes it.
    logic [WIDTH-1:0] result_reg, result_next;
    logic             neg_reg,    neg_next;
    logic             zero_reg,   zero_next;
    logic             err_reg,    err_next;

    // Requester-indexed views of the two input ports, so grant and
    // selection logic can be written once for both requesters.
    logic [1:0]       valid_vec;
    logic [3:0]       op_vec [2];
    logic [WIDTH-1:0] a_vec  [2];
    logic [WIDTH-1:0] b_vec  [2];
    logic [1:0]       ready_vec;

    logic             grant_valid;
    logic             grant_id;
    logic             accept;

    assign valid_vec[0] = req0_valid;
    assign valid_vec[1] = req1_valid;
    assign op_vec[0]    = req0_op;
    assign op_vec[1]    = req1_op;
    assign a_vec[0]     = req0_a;
    assign a_vec[1]     = req1_a;
    assign b_vec[0]     = req0_b;
    assign b_vec[1]     = req1_b;

    // Grant choice: a lone requester always wins. On a tie, the requester not served last time wins.
    always_comb begin
        grant_valid = |valid_vec;
        if (valid_vec == 2'b11) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = valid_vec[1];
        end
    end

    // Ready goes only to the granted requester, only in IDLE, and never while reset is asserted.
    // Ready already implies valid, so any ready bit means a handshake.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && !rst && grant_valid &&
                                   valid_vec[gi] && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |ready_vec;

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            result_reg     <= '0;
            neg_reg        <= 1'b0;
            zero_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            op_reg         <= op_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            id_reg         <= id_next;
            result_reg     <= result_next;
            neg_reg        <= neg_next;
            zero_reg       <= zero_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic: accept in IDLE, capture the ALU result in ISSUE, hand off in RESP.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        op_next         = op_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        id_next         = id_reg;
        result_next     = result_reg;
        neg_next        = neg_reg;
        zero_next       = zero_reg;
        err_next        = err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next = op_vec[grant_id];
                    a_next  = a_vec[grant_id];
                    b_next  = b_vec[grant_id];
                    id_next = grant_id;
                    if (op_vec[grant_id] == 4'd0) begin
                        // Op 0 is illegal. Reply at once with a fixed error payload.
                        result_next = '0;
                        neg_next    = 1'b0;
                        zero_next   = 1'b1;
                        err_next    = 1'b1;
                        state_next  = RESP;
                    end else begin
                        state_next  = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // The ALU is combinational. Its outputs are valid within this
                // cycle, so they are taken as-is at the end of the cycle.
                result_next = alu_out;
                neg_next    = alu_negative;
                zero_next   = alu_zero;
                err_next    = 1'b0;
                state_next  = RESP;
            end

            RESP: begin
                // No new request is taken on the handoff cycle. Ready is
                // available again only once the arbiter is back in IDLE.
                if (rsp_ready) begin
                    last_grant_next = id_reg;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU drive: the latched operation appears only during ISSUE. At all other times the ALU sees zeros.
    always_comb begin
        alu_input1    = '0;
        alu_input2    = '0;
        alu_operation = 4'd0;
        if (state_reg == ISSUE) begin
            alu_input1    = a_reg;
            alu_input2    = b_reg;
            alu_operation = op_reg;
        end
    end

    assign rsp_valid    = (state_reg == RESP);
    assign rsp_id       = id_reg;
    assign rsp_result   = result_reg;
    assign rsp_negative = neg_reg;
    assign rsp_zero     = zero_reg;
    assign rsp_err      = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven vectors, directed corner-case sequences and a
// randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_negative, rsp_zero, rsp_err;
    logic [31:0] alu_input1, alu_input2, alu_out;
    logic [3:0]  alu_operation;
    logic        alu_negative, alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_negative(rsp_negative),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_operation(alu_operation), .alu_out(alu_out),
        .alu_negative(alu_negative), .alu_zero(alu_zero)
    );

    // External ALU model, owned by the bench.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    always_comb begin
        alu_out      = alu_fn(alu_operation, alu_input1, alu_input2);
        alu_negative = alu_out[31];
        alu_zero     = (alu_out == 32'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0, v1;
        logic [3:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic        exp_id;
        logic [31:0] exp_result;
        logic        exp_neg, exp_zero, exp_err;
    } vec_t;

    vec_t vecs [8];

    // Run one vector from IDLE to completion, with rsp_ready held at 1 throughout.
    task automatic run_vec(input vec_t v, input int idx);
        int         lat;
        logic [3:0] eop;
        logic [31:0] ea;
        @(negedge clk);
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        rsp_ready  = 1'b1;
        #1;
        chk($sformatf("v%0d ready0", idx), 64'(req0_ready), 64'(v.exp_id == 1'b0));
        chk($sformatf("v%0d ready1", idx), 64'(req1_ready), 64'(v.exp_id == 1'b1));
        eop = v.exp_id ? v.op1 : v.op0;
        ea  = v.exp_id ? v.a1  : v.a0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        lat = 1;
        chk($sformatf("v%0d alu_op", idx), 64'(alu_operation), 64'(eop));
        chk($sformatf("v%0d alu_in1", idx), 64'(alu_input1), (eop != 4'd0) ? 64'(ea) : 64'd0);
        while (!rsp_valid && lat < 6) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), (eop == 4'd0) ? 64'd1 : 64'd2);
        chk($sformatf("v%0d rsp_id", idx), 64'(rsp_id), 64'(v.exp_id));
        chk($sformatf("v%0d result", idx), 64'(rsp_result), 64'(v.exp_result));
        chk($sformatf("v%0d neg", idx), 64'(rsp_negative), 64'(v.exp_neg));
        chk($sformatf("v%0d zero", idx), 64'(rsp_zero), 64'(v.exp_zero));
        chk($sformatf("v%0d err", idx), 64'(rsp_err), 64'(v.exp_err));
        $display("vec %0d: id=%0d result=%h lat=%0d", idx, rsp_id, rsp_result, lat);
    endtask

    // Reference model state for the random phase. It works at transaction
    // level: whether a request is in flight, how many cycles remain until
    // its reply, and the reply it must carry.
    bit          m_busy;
    int          m_wait;
    bit          m_last;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    bit          m_id, m_neg, m_zero, m_err;

    initial begin
        int w;
        // {v0,v1, op0,op1, a0,b0, a1,b1, id, result, neg, zero, err}
        vecs[0] = '{1,1, 4'd1,4'd2, 32'd15,32'd42, 32'd10,32'd3, 0, 32'd57,       0,0,0};
        vecs[1] = '{1,1, 4'd1,4'd2, 32'd15,32'd42, 32'd10,32'd3, 1, 32'd7,        0,0,0};
        vecs[2] = '{1,1, 4'd3,4'd1, 32'hF0F0,32'hFF00, 32'd1,32'd1, 0, 32'h0000F000, 0,0,0};
        vecs[3] = '{1,1, 4'd1,4'd2, 32'd1,32'd1, 32'd0,32'd3, 1, 32'hFFFFFFFD,   1,0,0};
        vecs[4] = '{0,1, 4'd1,4'd0, 32'd9,32'd9, 32'd5,32'd6, 1, 32'd0,          0,1,1};
        vecs[5] = '{1,0, 4'd2,4'd1, 32'd7,32'd7, 32'd1,32'd1, 0, 32'd0,          0,1,0};
        vecs[6] = '{0,1, 4'd1,4'd5, 32'd0,32'd0, 32'hA5A5A5A5,32'hFFFFFFFF, 1, 32'h5A5A5A5A, 0,0,0};
        vecs[7] = '{1,1, 4'd1,4'd1, 32'hFFFFFFFF,32'd1, 32'd2,32'd2, 0, 32'd0,   0,1,0};

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 4'd1; req1_op = 4'd1;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b0;

        // No requester may see ready while reset is held, even with both valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst ready0", 64'(req0_ready), 64'd0);
            chk("rst ready1", 64'(req1_ready), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_result", 64'(rsp_result), 64'd0);
        chk("reset rsp_flags", {61'd0, rsp_negative, rsp_zero, rsp_err}, 64'd0);
        chk("reset rsp_id", 64'(rsp_id), 64'd0);
        chk("reset alu_op", 64'(alu_operation), 64'd0);
        chk("reset alu_in", {alu_input1, alu_input2}, 64'd0);
        $display("reset: outputs checked");

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: the reply is held while req1 waits and is not accepted, including on the handoff cycle.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd100; req0_b = 32'd23;
        rsp_ready = 1'b0;
        #1;
        chk("bp accept0", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'h0F; req1_b = 32'hF0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp result", 64'(rsp_result), 64'd123);
            chk("bp rsp_id", 64'(rsp_id), 64'd0);
            chk("bp ready1", 64'(req1_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp handoff ready1", 64'(req1_ready), 64'd0);
        chk("bp handoff valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("bp idle ready1", 64'(req1_ready), 64'd1);
        chk("bp idle rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("bp issue alu_op", 64'(alu_operation), 64'd4);
        @(negedge clk);
        #1;
        chk("bp req1 rsp_valid", 64'(rsp_valid), 64'd1);
        chk("bp req1 result", 64'(rsp_result), 64'hFF);
        chk("bp req1 id", 64'(rsp_id), 64'd1);
        $display("backpressure: req1 result=%h", rsp_result);

        // Reset during ISSUE aborts the operation, and no reply follows.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        chk("abort accept", 64'(req0_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort issue alu_op", 64'(alu_operation), 64'd1);
        chk("abort ready0", 64'(req0_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0;
        #1;
        chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort alu_op", 64'(alu_operation), 64'd0);
        chk("abort result", 64'(rsp_result), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort no rsp", 64'(rsp_valid), 64'd0);
        end
        // Reset also restores the tie order, so requester 0 wins.
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'd0; req1_op = 4'd0;
        #1;
        chk("abort tie ready0", 64'(req0_ready), 64'd1);
        chk("abort tie ready1", 64'(req1_ready), 64'd0);
        $display("reset mid-op: aborted cleanly");

        // Randomized phase: start from a fresh reset and check against the model every cycle.
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 0; m_wait = 0; m_last = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_op = 4'($urandom_range(0, 7));
            req1_op = 4'($urandom_range(0, 7));
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (!m_busy) begin
                if (req0_valid && req1_valid) w = m_last ? 0 : 1;
                else if (req0_valid)          w = 0;
                else if (req1_valid)          w = 1;
            end
            chk("rnd ready0", 64'(req0_ready), 64'(w == 0));
            chk("rnd ready1", 64'(req1_ready), 64'(w == 1));
            chk("rnd rsp_valid", 64'(rsp_valid), 64'(m_busy && m_wait == 0));
            if (m_busy && m_wait == 0) begin
                chk("rnd rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rnd result", 64'(rsp_result), 64'(m_res));
                chk("rnd flags", {61'd0, rsp_negative, rsp_zero, rsp_err},
                    {61'd0, m_neg, m_zero, m_err});
            end
            if (m_busy && m_wait == 1) begin
                chk("rnd alu_drive", {28'd0, alu_operation, alu_input1, alu_input2}, {28'd0, m_op, m_a, m_b});
            end else begin
                chk("rnd alu_idle", {28'd0, alu_operation, alu_input1, alu_input2}, 92'd0);
            end
            // Advance the model across the coming rising edge.
            if (w >= 0) begin
                m_busy = 1;
                m_id   = (w == 1);
                m_op   = (w == 1) ? req1_op : req0_op;
                m_a    = (w == 1) ? req1_a  : req0_a;
                m_b    = (w == 1) ? req1_b  : req0_b;
                if (m_op == 4'd0) begin
                    m_wait = 0; m_res = 0; m_neg = 0; m_zero = 1; m_err = 1;
                end else begin
                    m_wait = 1;
                    m_res  = alu_fn(m_op, m_a, m_b);
                    m_neg  = m_res[31];
                    m_zero = (m_res == 32'd0);
                    m_err  = 0;
                end
                $display("rnd cycle %0d: accept id=%0d op=%0d", c, w, m_op);
            end else if (m_busy && m_wait == 1) begin
                m_wait = 0;
            end else if (m_busy && rsp_ready) begin
                m_busy = 0;
                m_last = m_id;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
